e203_ifu_ifq: RTL and testbench
===============================

Name: e203_ifu_ifq

Overview:
- Small instruction fetch queue between the IFU fetch-response path and the IR stage / mini-decoder.
- Buffers fetched instructions with their PC and error flags, and decouples fetch-response timing from IR consumption.
- Presents the head entry to the IR stage via a valid/ready handshake.
- Supports a single-cycle flush on redirect (branch mispredict, exception, debug entry).

Parameters:
- DEPTH, 2, number of queue entries; power of two, minimum 2.
- INSTR_W, 32, instruction width (E203_INSTR_SIZE).
- PC_W, 32, PC width (E203_PC_SIZE).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- i_valid  in  1  fetch response valid.
- i_ready  out  1  queue accepts the fetch response.
- i_instr  in  INSTR_W  fetched instruction.
- i_pc  in  PC_W  PC of the fetched instruction.
- i_buserr  in  1  bus error on fetch.
- i_misalgn  in  1  misaligned fetch.
- o_valid  out  1  head entry valid toward the IR stage.
- o_ready  in  1  IR stage consumes the head.
- o_instr  out  INSTR_W  head instruction (feeds the mini-decoder instr input).
- o_pc  out  PC_W  head PC.
- o_buserr  out  1  head bus-error flag.
- o_misalgn  out  1  head misaligned flag.
- flush  in  1  discard all entries this cycle.
- o_count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Clocking and reset:
  - Single clock domain; every register updates on the rising edge of clk.
  - rst is sampled synchronously.
  - While rst=1, the next edge sets write pointer, read pointer and count to 0.
  - Reset values: o_valid=0, o_count=0, i_ready=0 during reset. o_instr, o_pc and flag outputs are don't-care when o_valid=0, but must not be X after reset; entry storage resets to 0.
- Push:
  - Occurs when i_valid & i_ready.
  - Writes {instr, pc, buserr, misalgn} at the write pointer.
  - Write pointer increments modulo DEPTH.
- Pop:
  - Occurs when o_valid & o_ready.
  - Read pointer increments modulo DEPTH.
- Ready and valid:
  - i_ready = ~full & ~flush & ~rst.
  - No bypass when full: a push is never accepted in a full cycle, even if a pop happens in the same cycle.
  - o_valid = ~empty & ~flush.
  - o_* data is read combinationally from the entry at the read pointer. No fall-through from input to output: latency from push to o_valid is exactly 1 cycle.
- Count update per edge (all with no flush):
  - push only: +1.
  - pop only: -1.
  - push and pop together (only possible when 0 < count < DEPTH): count unchanged.
- Full and empty:
  - full = (count == DEPTH).
  - empty = (count == 0).
  - Pointers wrap silently.
  - Overflow and underflow are impossible by construction. Verification asserts count never exceeds DEPTH.
- Flush:
  - Takes priority over push and pop.
  - On the edge where flush=1, pointers and count go to 0.
  - Any i_valid during the flush cycle is dropped; i_ready=0 in that cycle.
  - The next cycle accepts pushes normally.
- Reset during operation:
  - Identical to flush: all entries are discarded and o_valid=0 from the next cycle.
- Stability:
  - While o_valid=1 and o_ready=0, o_instr, o_pc and the flags hold stable.
- Flag handling:
  - Error flags travel with their entry and are never merged.
  - An entry with i_buserr=1 is queued and popped like any other entry.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0 -> o_valid=0, o_count=0, i_ready=1.
- Fill: push 0x00000013 @pc 0x80000000, then 0x00100093 @pc 0x80000004, with o_ready=0 -> o_count=2, i_ready=0, o_instr=0x00000013. A third push of 0x00200113 is not accepted.
- Drain order: from the full state, o_ready=1 for 2 cycles -> o_instr/o_pc = 0x00000013/0x80000000, then 0x00100093/0x80000004. Then o_valid=0 and o_count=0.
- Simultaneous push and pop at count=1 (head 0x0000006F, pushing 0xFE000EE3) -> count stays 1, next head = 0xFE000EE3. Pointer wrap is exercised over 5 consecutive push+pop cycles with no loss or reordering.
- Flush: with count=2 and i_valid=1 carrying 0x00000073, assert flush for 1 cycle -> i_ready=0 and o_valid=0 that cycle. Next cycle o_count=0 and 0x00000073 never appears on o_instr.
- Error flag: push with i_buserr=1, i_pc=0x80000010 -> the popped entry shows o_buserr=1 and o_pc=0x80000010. The adjacent normal entries show o_buserr=0.

Source files
------------

// File: rtl/e203_ifu_ifq_if.sv
// Fetch-queue bus interface.
// Groups the fetch-response side (i_*), the IR-stage side (o_*), the flush
// request and the occupancy readout into one bundle.
//   master : the surroundings (fetch unit, IR stage, redirect logic)
//   slave  : the queue itself
interface e203_ifu_ifq_if #(
  parameter int DEPTH   = 2,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               i_valid;
  logic               i_ready;
  logic [INSTR_W-1:0] i_instr;
  logic [PC_W-1:0]    i_pc;
  logic               i_buserr;
  logic               i_misalgn;

  logic               o_valid;
  logic               o_ready;
  logic [INSTR_W-1:0] o_instr;
  logic [PC_W-1:0]    o_pc;
  logic               o_buserr;
  logic               o_misalgn;

  logic               flush;
  logic [CW-1:0]      o_count;

  modport slave (
    input  i_valid, i_instr, i_pc, i_buserr, i_misalgn, o_ready, flush,
    output i_ready, o_valid, o_instr, o_pc, o_buserr, o_misalgn, o_count
  );

  modport master (
    output i_valid, i_instr, i_pc, i_buserr, i_misalgn, o_ready, flush,
    input  i_ready, o_valid, o_instr, o_pc, o_buserr, o_misalgn, o_count
  );
endinterface

// File: rtl/e203_ifu_ifq.sv
// Instruction fetch queue between the IFU fetch-response path and the IR stage.
// Each entry holds {instr, pc, buserr, misalgn}. The head entry is presented
// combinationally to the IR stage; a new entry becomes visible one cycle after
// it is pushed (no fall-through). A flush or reset empties the queue in one
// cycle.
// Ports:
//   clk  : core clock
//   rst  : synchronous active-high reset
//   ifq  : slave side of e203_ifu_ifq_if (fetch response in, head out,
//          flush request, occupancy)
module e203_ifu_ifq #(
  parameter int DEPTH   = 2,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  e203_ifu_ifq_if.slave    ifq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [DEPTH-1:0]   buserr_mem;
  logic [DEPTH-1:0]   misalgn_mem;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full queue never accepts, even when the head is leaving this cycle,
  // so i_ready does not depend on o_ready.
  assign ifq.i_ready = ~full & ~ifq.flush & ~rst;
  assign ifq.o_valid = ~empty & ~ifq.flush;

  assign push = ifq.i_valid & ifq.i_ready;
  assign pop  = ifq.o_valid & ifq.o_ready;

  assign ifq.o_instr   = instr_mem[rd_ptr];
  assign ifq.o_pc      = pc_mem[rd_ptr];
  assign ifq.o_buserr  = buserr_mem[rd_ptr];
  assign ifq.o_misalgn = misalgn_mem[rd_ptr];
  assign ifq.o_count   = count;

  // Pointers and occupancy. Flush has the same effect as reset on the
  // control state; DEPTH is a power of two so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || ifq.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage. Cleared on reset so the head outputs are never X;
  // a flush leaves stale contents behind, which are masked by o_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
      buserr_mem  <= '0;
      misalgn_mem <= '0;
    end else if (push) begin
      instr_mem[wr_ptr]   <= ifq.i_instr;
      pc_mem[wr_ptr]      <= ifq.i_pc;
      buserr_mem[wr_ptr]  <= ifq.i_buserr;
      misalgn_mem[wr_ptr] <= ifq.i_misalgn;
    end
  end
endmodule

// File: tb/tb_e203_ifu_ifq.sv
// Self-checking bench for e203_ifu_ifq: directed vector table, a hand-written
// pointer-wrap sequence, then randomized traffic against a queue model.
module tb_e203_ifu_ifq;
  localparam int DEPTH   = 2;
  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  typedef struct {
    logic        rst;
    logic        i_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        buserr;
    logic        misalgn;
    logic        o_ready;
    logic        flush;
  } stim_t;

  typedef struct {
    logic        iready;
    logic        ovalid;
    int          count;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        buserr;
    logic        misalgn;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        buserr;
    logic        misalgn;
  } entry_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  vec_t   vecs[$];
  entry_t model_q[$];

  e203_ifu_ifq_if #(.DEPTH(DEPTH), .INSTR_W(INSTR_W), .PC_W(PC_W)) ifq_bus ();

  e203_ifu_ifq #(.DEPTH(DEPTH), .INSTR_W(INSTR_W), .PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .ifq (ifq_bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  function automatic stim_t st(logic r, logic v, logic [31:0] instr, logic [31:0] pc,
                               logic be, logic ma, logic ordy, logic fl);
    stim_t s;
    s.rst = r; s.i_valid = v; s.instr = instr; s.pc = pc;
    s.buserr = be; s.misalgn = ma; s.o_ready = ordy; s.flush = fl;
    return s;
  endfunction

  function automatic exp_t ex(logic ir, logic ov, int cnt, logic [31:0] instr,
                              logic [31:0] pc, logic be, logic ma);
    exp_t e;
    e.iready = ir; e.ovalid = ov; e.count = cnt; e.instr = instr;
    e.pc = pc; e.buserr = be; e.misalgn = ma;
    return e;
  endfunction

  task automatic addVec(stim_t s, exp_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    vecs.push_back(v);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Inputs change on the falling edge, well away from the sampling edge.
  task automatic applyStimulus(stim_t s);
    @(negedge clk);
    rst               = s.rst;
    ifq_bus.i_valid   = s.i_valid;
    ifq_bus.i_instr   = s.instr;
    ifq_bus.i_pc      = s.pc;
    ifq_bus.i_buserr  = s.buserr;
    ifq_bus.i_misalgn = s.misalgn;
    ifq_bus.o_ready   = s.o_ready;
    ifq_bus.flush     = s.flush;
  endtask

  task automatic checkOutput(string tag, exp_t e);
    #1;
    chk({tag, " i_ready"}, 32'(ifq_bus.i_ready), 32'(e.iready));
    chk({tag, " o_valid"}, 32'(ifq_bus.o_valid), 32'(e.ovalid));
    chk({tag, " o_count"}, 32'(ifq_bus.o_count), 32'(e.count));
    chk({tag, " count_bound"}, 32'(ifq_bus.o_count <= DEPTH), 32'd1);
    if (e.ovalid) begin
      chk({tag, " o_instr"},   ifq_bus.o_instr,           e.instr);
      chk({tag, " o_pc"},      ifq_bus.o_pc,              e.pc);
      chk({tag, " o_buserr"},  32'(ifq_bus.o_buserr),     32'(e.buserr));
      chk({tag, " o_misalgn"}, 32'(ifq_bus.o_misalgn),    32'(e.misalgn));
    end
  endtask

  // Main test sequence: directed table, wrap sequence, randomized traffic.
  initial begin
    stim_t s;
    exp_t  e;
    entry_t ent;

    ifq_bus.i_valid   = 1'b0;
    ifq_bus.i_instr   = '0;
    ifq_bus.i_pc      = '0;
    ifq_bus.i_buserr  = 1'b0;
    ifq_bus.i_misalgn = 1'b0;
    ifq_bus.o_ready   = 1'b0;
    ifq_bus.flush     = 1'b0;

    // Reset then idle
    addVec(st(1,0,0,0,0,0,0,0),                     ex(0,0,0,0,0,0,0));
    addVec(st(0,0,0,0,0,0,0,0),                     ex(1,0,0,0,0,0,0));
    // Fill to full, third push refused
    addVec(st(0,1,32'h00000013,32'h80000000,0,0,0,0), ex(1,0,0,0,0,0,0));
    addVec(st(0,1,32'h00100093,32'h80000004,0,0,0,0), ex(1,1,1,32'h00000013,32'h80000000,0,0));
    addVec(st(0,1,32'h00200113,32'h80000008,0,0,0,0), ex(0,1,2,32'h00000013,32'h80000000,0,0));
    // Drain in order
    addVec(st(0,0,0,0,0,0,1,0),                     ex(0,1,2,32'h00000013,32'h80000000,0,0));
    addVec(st(0,0,0,0,0,0,1,0),                     ex(1,1,1,32'h00100093,32'h80000004,0,0));
    addVec(st(0,0,0,0,0,0,1,0),                     ex(1,0,0,0,0,0,0));
    // Simultaneous push and pop at count 1
    addVec(st(0,1,32'h0000006F,32'h80000020,0,0,0,0), ex(1,0,0,0,0,0,0));
    addVec(st(0,1,32'hFE000EE3,32'h80000024,0,0,1,0), ex(1,1,1,32'h0000006F,32'h80000020,0,0));
    addVec(st(0,0,0,0,0,0,0,0),                     ex(1,1,1,32'hFE000EE3,32'h80000024,0,0));
    // Flush with count 2 and a pending fetch response
    addVec(st(0,1,32'h00000013,32'h80000028,0,0,0,0), ex(1,1,1,32'hFE000EE3,32'h80000024,0,0));
    addVec(st(0,1,32'h00000073,32'h8000002C,0,0,0,1), ex(0,0,2,0,0,0,0));
    addVec(st(0,0,0,0,0,0,1,0),                     ex(1,0,0,0,0,0,0));
    // Bus-error entry between two normal entries
    addVec(st(0,1,32'h11111111,32'h8000000C,0,0,0,0), ex(1,0,0,0,0,0,0));
    addVec(st(0,1,32'h22222222,32'h80000010,1,0,0,0), ex(1,1,1,32'h11111111,32'h8000000C,0,0));
    addVec(st(0,0,0,0,0,0,1,0),                     ex(0,1,2,32'h11111111,32'h8000000C,0,0));
    addVec(st(0,1,32'h33333333,32'h80000014,0,0,1,0), ex(1,1,1,32'h22222222,32'h80000010,1,0));
    addVec(st(0,0,0,0,0,0,1,0),                     ex(1,1,1,32'h33333333,32'h80000014,0,0));
    addVec(st(0,0,0,0,0,0,0,0),                     ex(1,0,0,0,0,0,0));
    // Reset during operation, misaligned entry discarded
    addVec(st(0,1,32'hAAAAAAAA,32'h80000030,0,1,0,0), ex(1,0,0,0,0,0,0));
    addVec(st(1,1,32'hBBBBBBBB,32'h80000034,0,0,0,0), ex(0,1,1,32'hAAAAAAAA,32'h80000030,0,1));
    addVec(st(0,0,0,0,0,0,0,0),                     ex(1,0,0,0,0,0,0));

    $display("[TB] power-up reset cycle");
    applyStimulus(st(1,0,0,0,0,0,0,0));

    $display("[TB] directed table: %0d vectors", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].s);
      checkOutput($sformatf("vec%0d", i), vecs[i].e);
    end

    $display("[TB] pointer wrap over 5 push+pop cycles");
    applyStimulus(st(0,1,32'h00001000,32'h90000000,0,0,0,0));
    checkOutput("wrap0", ex(1,0,0,0,0,0,0));
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(st(0,1,32'h00001000 + 32'(k),32'h90000000 + 32'(4*k),0,0,1,0));
      checkOutput($sformatf("wrap%0d", k),
                  ex(1,1,1,32'h00001000 + 32'(k-1),32'h90000000 + 32'(4*(k-1)),0,0));
    end
    applyStimulus(st(0,0,0,0,0,0,1,0));
    checkOutput("wrap6", ex(1,1,1,32'h00001005,32'h90000014,0,0));
    applyStimulus(st(0,0,0,0,0,0,0,0));
    checkOutput("wrap7", ex(1,0,0,0,0,0,0));

    $display("[TB] randomized traffic against queue model");
    model_q.delete();
    for (int n = 0; n < 800; n++) begin
      s.rst     = ($urandom_range(0, 39) == 0);
      s.flush   = ($urandom_range(0, 15) == 0);
      s.i_valid = ($urandom_range(0, 9) < 7);
      s.instr   = $urandom;
      s.pc      = $urandom & 32'hFFFF_FFFC;
      s.buserr  = ($urandom_range(0, 7) == 0);
      s.misalgn = ($urandom_range(0, 7) == 0);
      s.o_ready = ($urandom_range(0, 9) < 6);

      e.iready = (model_q.size() < DEPTH) && !s.flush && !s.rst;
      e.ovalid = (model_q.size() > 0) && !s.flush;
      e.count  = model_q.size();
      if (model_q.size() > 0) begin
        e.instr   = model_q[0].instr;
        e.pc      = model_q[0].pc;
        e.buserr  = model_q[0].buserr;
        e.misalgn = model_q[0].misalgn;
      end else begin
        e.instr = '0; e.pc = '0; e.buserr = 1'b0; e.misalgn = 1'b0;
      end

      applyStimulus(s);
      checkOutput("rand", e);

      if (s.rst || s.flush) begin
        model_q.delete();
      end else begin
        if (e.ovalid && s.o_ready) void'(model_q.pop_front());
        if (s.i_valid && e.iready) begin
          ent.instr   = s.instr;
          ent.pc      = s.pc;
          ent.buserr  = s.buserr;
          ent.misalgn = s.misalgn;
          model_q.push_back(ent);
        end
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
